iob_merge_arb: RTL and testbench
================================

# iob_merge_arb

Round-robin arbiter that shares one IOb native slave port among N_MASTERS requesting masters; the mirror of the address-decoding splitter on the fan-in side of the interconnect. Each transaction is granted to one master, forwarded unchanged to the slave, and the slave's response is routed back only to the granted master. Grants are registered, and only one transaction is outstanding at a time.

## Interface
- DATA_W, 32, data width
- ADDR_W, 32, address width
- N_MASTERS, 2, number of requesting masters (≥1)
- Derived: REQ_W = 1+ADDR_W+DATA_W+DATA_W/8, packed MSB→LSB as {valid, addr, wdata, wstrb}; RESP_W = DATA_W+1, packed as {rdata, ready}; Nb = max(1, clog2(N_MASTERS))
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- m_req  input  N_MASTERS*REQ_W  master requests, master i at slice i
- m_resp  output  N_MASTERS*RESP_W  master responses, master i at slice i
- s_req  output  REQ_W  request to shared slave
- s_resp  input  RESP_W  response from shared slave
- grant  output  N_MASTERS  registered one-hot grant, all-zero when idle
- busy  output  1  high while a transaction is in progress

## Operation
- FSM with two states, IDLE and BUSY, plus pointer `last` (Nb bits, index of the last granted master).
- IDLE: search the masters with valid=1, starting at index (last+1) mod N_MASTERS and wrapping. On a hit at index k, set grant ← one-hot(k) and go to BUSY on the next edge. With no valid master, stay in IDLE.
- BUSY:
  - s_req = m_req slice of the granted master.
  - m_resp slice of the granted master = s_resp.
  - Every other m_resp slice = 0.
- BUSY and s_resp.ready=1: on the next edge, last ← k, grant ← 0, state ← IDLE.
- BUSY and granted master valid=0 before ready (protocol violation/abort): on the next edge, return to IDLE with last ← k. A ready arriving later is not routed to any master.
- IDLE: s_req = 0 and all m_resp = 0, regardless of s_resp.
- Masters hold valid and the request fields stable until they observe ready=1. Ready is a one-cycle pulse per transaction.
- N_MASTERS=1: the arbitration is trivial, but the FSM timing is identical.
- busy = (state == BUSY).

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, last=N_MASTERS-1 (master 0 wins first), grant=0, busy=0, s_req=0, m_resp=0.
- Reset deassertion: takes effect on the first rising edge with rst_n=1.
- Reset mid-transaction: the transaction is dropped and outputs return to reset values immediately. The master must reissue.
- Grant latency: a request valid in IDLE cycle t produces grant and s_req.valid in cycle t+1.
- Slave ready: may assert in the first BUSY cycle (combinational slave) or any later cycle. m_resp.ready is in the same cycle as s_resp.ready, with no added latency.
- Minimum period: 2 cycles per transaction (1 IDLE + 1 BUSY). The next grant follows ready by exactly 1 cycle.
- Request during BUSY: requests from non-granted masters are held pending and are not lost. They are arbitrated in the following IDLE cycle.
- Simultaneous requests: the lowest index at or after (last+1) wins, with wrap-around. With all masters continuously requesting, the grant order is strictly 0,1,…,N-1,0,…
- Outputs s_req and m_resp are combinational from the registered grant/state and the inputs. grant and busy are registered.

## Test plan
- Reset: hold rst_n=0 while m_req has valid=1 → grant=0, busy=0, s_req=0, all m_resp=0. Release reset → grant=01 next cycle.
- Single master: master 1 writes addr 0x10, wdata 0xA5A5A5A5, wstrb 0xF; slave ready after 3 cycles → s_req matches exactly in BUSY, m_resp[1].ready pulses once, m_resp[0]=0.
- Contention, N_MASTERS=4: all masters continuously valid, slave ready on the first BUSY cycle → grants 0,1,2,3,0 on cycles 1,3,5,7,9. Each master receives rdata = 0x100+i.
- Wrap and skip: last=2, only masters 0 and 1 valid → master 0 granted, then master 1.
- Abort: the granted master drops valid before ready → IDLE next cycle. A late ready=1 with rdata 0xDEAD is not seen on any m_resp.
- Reset mid-BUSY: assert rst_n=0 between edges → grant and s_req go to 0 without waiting for a clock edge. After release, master 0 is arbitrated first.

Source files
------------

// File: rtl/iob_merge_arb.sv
// Round-robin fan-in arbiter: N IOb masters share one slave, one transaction in flight.
// Grant one cycle after a request in IDLE; slave ready is routed back in the same cycle.
module iob_merge_arb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int N_MASTERS = 2,
  localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W   = DATA_W + 1,
  localparam int NB       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp,
  output logic [N_MASTERS-1:0]        grant,
  output logic                        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q;
  logic [NB-1:0]          last_q;
  logic [NB-1:0]          gidx_q;
  logic [N_MASTERS-1:0]   grant_q;

  logic [N_MASTERS-1:0]   vld;
  logic [N_MASTERS-1:0]   hit_oh;
  logic [NB-1:0]          hit_idx;
  logic                   hit;
  logic                   gnt_vld;

  always_comb begin
    vld = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      vld[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

  // Walk offsets 1..N from the last winner so the search wraps past the end.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      for (int j = 0; j < N_MASTERS; j++) begin
        if (!hit && vld[j] && (j == (int'(last_q) + off) % N_MASTERS)) begin
          hit       = 1'b1;
          hit_idx   = NB'(j);
          hit_oh[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_req   = '0;
    m_resp  = '0;
    gnt_vld = 1'b0;
    if (state_q == BUSY) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (gidx_q == NB'(i)) begin
          s_req                        = m_req[i*REQ_W +: REQ_W];
          m_resp[i*RESP_W +: RESP_W]   = s_resp;
          gnt_vld                      = vld[i];
        end
      end
    end
  end

  // A granted master dropping valid before ready aborts the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= NB'(N_MASTERS - 1);
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= BUSY;
            gidx_q  <= hit_idx;
            grant_q <= hit_oh;
          end
        end
        BUSY: begin
          if (s_resp[0] || !gnt_vld) begin
            state_q <= IDLE;
            last_q  <= gidx_q;
            grant_q <= '0;
          end
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_iob_merge_arb.sv
// Bench for iob_merge_arb with four masters: directed scenarios plus random traffic,
// checked by a round-robin reference model and a response scoreboard.
module tb_iob_merge_arb;
  localparam int N      = 4;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N*REQ_W-1:0]   m_req;
  logic [N*RESP_W-1:0]  m_resp;
  logic [REQ_W-1:0]     s_req;
  logic [RESP_W-1:0]    s_resp;
  logic [N-1:0]         grant;
  logic                 busy;

  always #5 clk = ~clk;

  iob_merge_arb #(.DATA_W(32), .ADDR_W(32), .N_MASTERS(N)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .grant(grant), .busy(busy)
  );

  typedef struct {
    int          m;
    logic [31:0] rd;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  int          gseq[$];
  int          gcyc[$];
  int          cyc = 0;
  int          rdy_cnt[N];
  logic [N-1:0] act = '0;
  logic [N-1:0] rdy_seen = '0;
  logic [31:0] ad[N];
  logic [31:0] wd[N];
  logic [3:0]  ws[N];
  int          auto_n[N];
  bit          rnd_en = 0;
  bit          spur_en = 0;
  bit          spur_force = 0;
  int          fixed_dly = -1;

  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic put_req();
    for (int i = 0; i < N; i++) m_req[i*REQ_W +: REQ_W] = {act[i], ad[i], wd[i], ws[i]};
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    exp_t e;
    act[i] = 1'b1; ad[i] = a; wd[i] = w; ws[i] = s;
    e.m = i; e.rd = a ^ w;
    sb.push_back(e);
    put_req();
  endtask

  task automatic sb_take(input int i, output bit ok, output logic [31:0] rd);
    ok = 0; rd = '0;
    for (int k = 0; k < sb.size(); k++) begin
      if (!ok && sb[k].m == i) begin
        ok = 1; rd = sb[k].rd; sb.delete(k);
      end
    end
  endtask

  // Masters: finish on ready, optionally reissue, abort or start random requests.
  initial begin
    bit          ok;
    logic [31:0] rd;
    forever begin
      @(negedge clk); #2;
      for (int i = 0; i < N; i++) rdy_seen[i] = m_resp[i*RESP_W];
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (act[i] && rdy_seen[i]) begin
          act[i] = 1'b0;
          if (auto_n[i] > 0) begin
            auto_n[i]--;
            issue(i, ad[i], wd[i], ws[i]);
          end
        end else if (rnd_en && act[i] && grant[i] && $urandom_range(19) == 0) begin
          act[i] = 1'b0;
          sb_take(i, ok, rd);
        end else if (rnd_en && !act[i] && $urandom_range(2) == 0) begin
          issue(i, $urandom, $urandom, 4'($urandom));
        end
      end
      put_req();
    end
  end

  // Slave: answers rdata = addr ^ wdata after a delay; may emit stray readies when idle.
  initial begin
    int cnt;
    int dly;
    cnt = 0; dly = 0;
    s_resp = '0;
    forever begin
      @(negedge clk); #1;
      if (s_req[REQ_W-1]) begin
        if (cnt >= dly) begin
          s_resp = {s_req[REQ_W-2 -: 32] ^ s_req[REQ_W-34 -: 32], 1'b1};
          cnt = 0;
        end else cnt++;
      end else begin
        cnt = 0;
        dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(3));
        if (spur_force || (spur_en && $urandom_range(7) == 0)) s_resp = {32'hDEAD, 1'b1};
      end
      @(posedge clk); #1;
      s_resp = '0;
    end
  end

  // Monitor: abstract round-robin model plus response scoreboard.
  initial begin
    bit                 mb;
    int                 mk;
    int                 ml;
    bit                 pb;
    bit                 ok;
    bit                 kv;
    logic [31:0]        rd;
    logic [N-1:0]       eg;
    logic [REQ_W-1:0]   es;
    logic [N*RESP_W-1:0] er;
    mb = 0; mk = 0; ml = N - 1; pb = 0;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        mb = 0; ml = N - 1; pb = 0;
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sreq", s_req, '0);
        chk("rst_mresp", m_resp, '0);
      end else begin
        eg = '0; es = '0; er = '0; kv = 0;
        if (mb) begin
          eg[mk] = 1'b1;
          es = m_req[mk*REQ_W +: REQ_W];
          er[mk*RESP_W +: RESP_W] = s_resp;
          kv = m_req[mk*REQ_W + REQ_W - 1];
        end
        chk("grant", grant, eg);
        chk("busy", busy, mb);
        chk("s_req", s_req, es);
        chk("m_resp", m_resp, er);
        for (int i = 0; i < N; i++) begin
          if (m_resp[i*RESP_W] && act[i]) begin
            rdy_cnt[i]++;
            sb_take(i, ok, rd);
            chk("sb_expected", ok, 1'b1);
            if (ok) chk("sb_rdata", m_resp[i*RESP_W+1 +: 32], rd);
          end
        end
        if (busy && !pb) begin
          for (int i = 0; i < N; i++) if (grant[i]) begin gseq.push_back(i); gcyc.push_back(cyc); end
        end
        pb = busy;
        if (mb) begin
          if (s_resp[0] || !kv) begin mb = 0; ml = mk; end
        end else begin
          for (int off = 1; off <= N; off++) begin
            int j;
            j = (ml + off) % N;
            if (!mb && m_req[j*REQ_W + REQ_W - 1]) begin mb = 1; mk = j; end
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((act != '0 || busy) && b < 400) begin step(); b++; end
    chk("idle_timeout", b < 400, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit ok;
    logic [31:0] rd;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      ad[i] = '0; wd[i] = '0; ws[i] = '0; auto_n[i] = 0; rdy_cnt[i] = 0;
    end
    put_req();
    issue(0, 32'h40, 32'h1, 4'h1);
    issue(3, 32'h44, 32'h2, 4'h2);
    repeat (3) step();
    chk("rst_hold_grant", grant, '0);
    chk("rst_hold_sreq", s_req, '0);
    rst_n = 1'b1;
    step();
    chk("release_grant", grant, 4'b0001);
    wait_idle();
    chk("release_order_n", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("release_order0", gseq[0], 0);
      chk("release_order1", gseq[1], 3);
    end

    // contention: everyone requests twice, zero-latency slave
    fixed_dly = 0;
    gseq.delete(); gcyc.delete();
    for (int i = 0; i < N; i++) auto_n[i] = 1;
    for (int i = 0; i < N; i++) issue(i, 32'h100 + i, 32'h0, 4'hF);
    t0 = cyc;
    wait_idle();
    chk("cont_n", gseq.size(), 8);
    if (gseq.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("cont_idx", gseq[k], k % N);
        chk("cont_cyc", gcyc[k], t0 + 1 + 2 * k);
      end
    end

    // single master with a slow slave
    fixed_dly = 3;
    rdy_cnt[1] = 0;
    issue(1, 32'h10, 32'hA5A5A5A5, 4'hF);
    step();
    chk("single_grant", grant, 4'b0010);
    chk("single_sreq", s_req, {1'b1, 32'h10, 32'hA5A5A5A5, 4'hF});
    chk("single_mresp_wait", m_resp, '0);
    wait_idle();
    repeat (3) step();
    chk("single_rdy_cnt", rdy_cnt[1], 1);

    // wrap and skip: last=2, then masters 0 and 1
    fixed_dly = 1;
    gseq.delete();
    issue(2, 32'h200, 32'h5, 4'h3);
    wait_idle();
    issue(0, 32'h300, 32'h6, 4'h1);
    issue(1, 32'h304, 32'h7, 4'h8);
    wait_idle();
    chk("wrap_n", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("wrap0", gseq[0], 2);
      chk("wrap1", gseq[1], 0);
      chk("wrap2", gseq[2], 1);
    end

    // abort: granted master withdraws, a late ready must not leak
    fixed_dly = 6;
    issue(2, 32'h20, 32'h33, 4'h3);
    step();
    chk("abort_grant", grant, 4'b0100);
    act[2] = 1'b0;
    sb_take(2, ok, rd);
    put_req();
    step();
    chk("abort_idle", busy, 1'b0);
    spur_force = 1;
    @(negedge clk); #3;
    chk("abort_late_mresp", m_resp, '0);
    spur_force = 0;
    step();

    // asynchronous reset in the middle of a transaction
    fixed_dly = 8;
    issue(2, 32'h24, 32'h44, 4'h6);
    step();
    chk("midrst_grant", grant, 4'b0100);
    issue(0, 32'h28, 32'h55, 4'h9);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_grant0", grant, '0);
    chk("midrst_busy0", busy, 1'b0);
    chk("midrst_sreq0", s_req, '0);
    chk("midrst_mresp0", m_resp, '0);
    gseq.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("midrst_first", grant, 4'b0001);
    fixed_dly = -1;
    wait_idle();
    chk("midrst_n", gseq.size(), 2);
    if (gseq.size() == 2) chk("midrst_second", gseq[1], 2);

    // random traffic with aborts and stray readies
    rnd_en = 1; spur_en = 1;
    repeat (3000) @(posedge clk);
    rnd_en = 0; spur_en = 0;
    step();
    wait_idle();
    step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
